// File: rtl/regfile_mp_bypass.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_bypass
// Purpose  : Parametrised multi-port register file with write-first read
//            bypass, fixed write-conflict priority (highest port wins),
//            optional hardwired-zero register 0 and a per-register busy
//            scoreboard fed by allocate ports.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, all state updates on posedge
//   rst_n        in   asynchronous active-low reset
//   i_we         in   [WRITE_PORTS]        per-port write enable
//   i_waddr      in   [WRITE_PORTS*AW]     write register index
//   i_wdata      in   [WRITE_PORTS*SIZE]   write data
//   i_re         in   [READ_PORTS]         per-port read enable
//   i_raddr      in   [READ_PORTS*AW]      read register index
//   o_rdata      out  [READ_PORTS*SIZE]    registered read data
//   o_rbusy      out  [READ_PORTS]         registered busy flag of read reg
//   i_alloc_en   in   [ALLOC_PORTS]        mark register busy
//   i_alloc_reg  in   [ALLOC_PORTS*AW]     register to mark busy
//   o_busy_vec   out  [REG_NUM]            current scoreboard state
// ============================================================================
module regfile_mp_bypass #(
  parameter int SIZE        = 32,
  parameter int REG_NUM     = 8,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int ALLOC_PORTS = 2,
  parameter int ZERO_REG    = 1,
  localparam int AW         = $clog2(REG_NUM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WRITE_PORTS-1:0]        i_we,
  input  logic [WRITE_PORTS*AW-1:0]     i_waddr,
  input  logic [WRITE_PORTS*SIZE-1:0]   i_wdata,
  input  logic [READ_PORTS-1:0]         i_re,
  input  logic [READ_PORTS*AW-1:0]      i_raddr,
  output logic [READ_PORTS*SIZE-1:0]    o_rdata,
  output logic [READ_PORTS-1:0]         o_rbusy,
  input  logic [ALLOC_PORTS-1:0]        i_alloc_en,
  input  logic [ALLOC_PORTS*AW-1:0]     i_alloc_reg,
  output logic [REG_NUM-1:0]            o_busy_vec
);

  logic [SIZE-1:0] r_regs     [REG_NUM];
  logic [SIZE-1:0] w_regs_nxt [REG_NUM];
  logic [REG_NUM-1:0] r_busy;
  logic [REG_NUM-1:0] w_busy_nxt;

  logic [AW-1:0]   w_waddr     [WRITE_PORTS];
  logic [SIZE-1:0] w_wdata     [WRITE_PORTS];
  logic [AW-1:0]   w_alloc_reg [ALLOC_PORTS];

  // Unpack the flat port buses into per-port views.
  genvar gp;
  generate
    for (gp = 0; gp < WRITE_PORTS; gp++) begin : g_wport
      assign w_waddr[gp] = i_waddr[gp*AW +: AW];
      assign w_wdata[gp] = i_wdata[gp*SIZE +: SIZE];
    end
    for (gp = 0; gp < ALLOC_PORTS; gp++) begin : g_aport
      assign w_alloc_reg[gp] = i_alloc_reg[gp*AW +: AW];
    end
  endgenerate

  // Next-state register contents. Ports are applied in ascending order so a
  // later (higher-numbered) port overwrites an earlier one on a conflict.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      w_regs_nxt[i] = r_regs[i];
    end
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (i_we[p]) begin
        w_regs_nxt[w_waddr[p]] = w_wdata[p];
      end
    end
    if (ZERO_REG != 0) begin
      w_regs_nxt[0] = '0;
    end
  end

  // Next-state scoreboard: writes clear first, allocations are applied last
  // so an allocate on the same register as a write leaves it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (i_we[p]) begin
        w_busy_nxt[w_waddr[p]] = 1'b0;
      end
    end
    for (int a = 0; a < ALLOC_PORTS; a++) begin
      if (i_alloc_en[a]) begin
        w_busy_nxt[w_alloc_reg[a]] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= w_regs_nxt[i];
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy_vec = r_busy;

  // Read ports sample the next-state view, giving write-first bypass with the
  // same conflict priority as the storage itself.
  generate
    for (gp = 0; gp < READ_PORTS; gp++) begin : g_rport
      logic [AW-1:0]   w_raddr;
      logic [SIZE-1:0] r_rdata;
      logic            r_rbusy;

      assign w_raddr = i_raddr[gp*AW +: AW];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rdata <= '0;
          r_rbusy <= 1'b0;
        end else if (i_re[gp]) begin
          r_rdata <= w_regs_nxt[w_raddr];
          r_rbusy <= w_busy_nxt[w_raddr];
        end
      end

      assign o_rdata[gp*SIZE +: SIZE] = r_rdata;
      assign o_rbusy[gp]              = r_rbusy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_bypass.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp_bypass
// Purpose  : Bench for regfile_mp_bypass. Two instances: the default
//            configuration and a wide sweep configuration (32 regs, 4 read,
//            3 write, 1 alloc port, 64-bit data). A register-level model
//            tracks both and is compared on every falling edge, and directed
//            scenarios pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_bypass;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance (SIZE 32, 8 regs, 2R/2W/2A)
  logic [1:0]   d_we;
  logic [5:0]   d_waddr;
  logic [63:0]  d_wdata;
  logic [1:0]   d_re;
  logic [5:0]   d_raddr;
  logic [63:0]  d_rdata;
  logic [1:0]   d_rbusy;
  logic [1:0]   d_alloc_en;
  logic [5:0]   d_alloc_reg;
  logic [7:0]   d_busy_vec;

  // Sweep instance (SIZE 64, 32 regs, 4R/3W/1A)
  logic [2:0]   s_we;
  logic [14:0]  s_waddr;
  logic [191:0] s_wdata;
  logic [3:0]   s_re;
  logic [19:0]  s_raddr;
  logic [255:0] s_rdata;
  logic [3:0]   s_rbusy;
  logic [0:0]   s_alloc_en;
  logic [4:0]   s_alloc_reg;
  logic [31:0]  s_busy_vec;

  regfile_mp_bypass dut (
    .clk(clk), .rst_n(rst_n),
    .i_we(d_we), .i_waddr(d_waddr), .i_wdata(d_wdata),
    .i_re(d_re), .i_raddr(d_raddr), .o_rdata(d_rdata), .o_rbusy(d_rbusy),
    .i_alloc_en(d_alloc_en), .i_alloc_reg(d_alloc_reg), .o_busy_vec(d_busy_vec)
  );

  regfile_mp_bypass #(
    .SIZE(64), .REG_NUM(32), .READ_PORTS(4), .WRITE_PORTS(3),
    .ALLOC_PORTS(1), .ZERO_REG(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
    .i_we(s_we), .i_waddr(s_waddr), .i_wdata(s_wdata),
    .i_re(s_re), .i_raddr(s_raddr), .o_rdata(s_rdata), .o_rbusy(s_rbusy),
    .i_alloc_en(s_alloc_en), .i_alloc_reg(s_alloc_reg), .o_busy_vec(s_busy_vec)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (index 0 = default, 1 = sweep) ---------
  logic [63:0] m_regs  [2][32];
  bit          m_busy  [2][32];
  logic [63:0] e_rdata [2][4];
  bit          e_rbusy [2][4];
  bit          c_we [2][3];
  int          c_wa [2][3];
  logic [63:0] c_wd [2][3];
  bit          c_re [2][4];
  int          c_ra [2][4];
  bit          c_ae [2][2];
  int          c_ar [2][2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = '0;
        m_busy[k][i] = 1'b0;
      end
      for (int r = 0; r < 4; r++) begin
        e_rdata[k][r] = '0;
        e_rbusy[k][r] = 1'b0;
      end
    end
  endtask

  // For each register: find the highest-numbered writer, then let any
  // allocation override the busy flag; register 0 is constant zero/idle.
  task automatic model_edge(input int k, input int nw, input int nr, input int na, input int nreg);
    logic [63:0] nv [32];
    bit          nb [32];
    int          winner;
    for (int i = 0; i < nreg; i++) begin
      nv[i] = m_regs[k][i];
      nb[i] = m_busy[k][i];
      winner = -1;
      for (int p = nw - 1; p >= 0; p--) begin
        if (winner < 0 && c_we[k][p] && c_wa[k][p] == i) winner = p;
      end
      if (winner >= 0) begin
        nv[i] = c_wd[k][winner];
        nb[i] = 1'b0;
      end
      for (int a = 0; a < na; a++) begin
        if (c_ae[k][a] && c_ar[k][a] == i) nb[i] = 1'b1;
      end
      if (i == 0) begin
        nv[i] = '0;
        nb[i] = 1'b0;
      end
    end
    for (int r = 0; r < nr; r++) begin
      if (c_re[k][r]) begin
        e_rdata[k][r] = nv[c_ra[k][r]];
        e_rbusy[k][r] = nb[c_ra[k][r]];
      end
    end
    for (int i = 0; i < nreg; i++) begin
      m_regs[k][i] = nv[i];
      m_busy[k][i] = nb[i];
    end
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        c_we[0][p] = d_we[p];
        c_wa[0][p] = int'(d_waddr[p*3 +: 3]);
        c_wd[0][p] = {32'b0, d_wdata[p*32 +: 32]};
        c_re[0][p] = d_re[p];
        c_ra[0][p] = int'(d_raddr[p*3 +: 3]);
        c_ae[0][p] = d_alloc_en[p];
        c_ar[0][p] = int'(d_alloc_reg[p*3 +: 3]);
      end
      for (int p = 0; p < 3; p++) begin
        c_we[1][p] = s_we[p];
        c_wa[1][p] = int'(s_waddr[p*5 +: 5]);
        c_wd[1][p] = s_wdata[p*64 +: 64];
      end
      for (int r = 0; r < 4; r++) begin
        c_re[1][r] = s_re[r];
        c_ra[1][r] = int'(s_raddr[r*5 +: 5]);
      end
      c_ae[1][0] = s_alloc_en[0];
      c_ar[1][0] = int'(s_alloc_reg);
      model_edge(0, 2, 2, 2, 8);
      model_edge(1, 3, 4, 1, 32);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      logic [31:0] bv;
      for (int r = 0; r < 2; r++) begin
        check("d_rdata", {32'b0, d_rdata[r*32 +: 32]}, e_rdata[0][r]);
        check("d_rbusy", 64'(d_rbusy[r]), 64'(e_rbusy[0][r]));
      end
      bv = '0;
      for (int i = 0; i < 8; i++) bv[i] = m_busy[0][i];
      check("d_busy_vec", 64'(d_busy_vec), 64'(bv));
      for (int r = 0; r < 4; r++) begin
        check("s_rdata", s_rdata[r*64 +: 64], e_rdata[1][r]);
        check("s_rbusy", 64'(s_rbusy[r]), 64'(e_rbusy[1][r]));
      end
      bv = '0;
      for (int i = 0; i < 32; i++) bv[i] = m_busy[1][i];
      check("s_busy_vec", 64'(s_busy_vec), 64'(bv));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    d_we = '0; d_re = '0; d_alloc_en = '0;
    s_we = '0; s_re = '0; s_alloc_en = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    d_we[p] = 1'b1;
    d_waddr[p*3 +: 3] = 3'(a);
    d_wdata[p*32 +: 32] = d;
  endtask

  task automatic rd(input int r, input int a);
    d_re[r] = 1'b1;
    d_raddr[r*3 +: 3] = 3'(a);
  endtask

  task automatic al(input int p, input int a);
    d_alloc_en[p] = 1'b1;
    d_alloc_reg[p*3 +: 3] = 3'(a);
  endtask

  task automatic s_wr(input int p, input int a, input logic [63:0] d);
    s_we[p] = 1'b1;
    s_waddr[p*5 +: 5] = 5'(a);
    s_wdata[p*64 +: 64] = d;
  endtask

  task automatic s_rd(input int r, input int a);
    s_re[r] = 1'b1;
    s_raddr[r*5 +: 5] = 5'(a);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    d_waddr = '0; d_wdata = '0; d_raddr = '0; d_alloc_reg = '0;
    s_waddr = '0; s_wdata = '0; s_raddr = '0; s_alloc_reg = '0;
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("reset rdata", d_rdata, 64'h0);
    check("reset rbusy", 64'(d_rbusy), 64'h0);
    check("reset busy_vec", 64'(d_busy_vec), 64'h0);
    rst_n = 1'b1;
    step();

    // Write r3, alloc r5, bypass-read r3, then reset between edges.
    wr(0, 3, 32'hDEADBEEF); al(0, 5); rd(0, 3);
    step();
    idle();
    check("pre-reset rdata r3", 64'(d_rdata[31:0]), 64'hDEADBEEF);
    check("pre-reset busy_vec", 64'(d_busy_vec), 64'h20);
    #2 rst_n = 1'b0;
    #1;
    check("async reset rdata", d_rdata, 64'h0);
    check("async reset busy_vec", 64'(d_busy_vec), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(0, 3); rd(1, 5);
    step();
    idle();
    check("post-reset read r3", 64'(d_rdata[31:0]), 64'h0);
    check("post-reset rbusy r5", 64'(d_rbusy[1]), 64'h0);

    // Basic latency and hold.
    wr(0, 2, 32'h11);
    step();
    idle();
    rd(0, 2);
    step();
    idle();
    check("basic read r2", 64'(d_rdata[31:0]), 64'h11);
    wr(0, 2, 32'h22);
    step();
    idle();
    check("hold with re=0", 64'(d_rdata[31:0]), 64'h11);

    // Bypass with write conflict: port 1 wins.
    wr(0, 4, 32'hAAAA); wr(1, 4, 32'h5555); rd(0, 4);
    step();
    idle();
    check("conflict bypass", 64'(d_rdata[31:0]), 64'h5555);
    rd(1, 4);
    step();
    idle();
    check("conflict stored", 64'(d_rdata[63:32]), 64'h5555);

    // Zero register.
    wr(0, 0, 32'hFFFFFFFF); al(0, 0); rd(0, 0);
    step();
    idle();
    check("zero rdata", 64'(d_rdata[31:0]), 64'h0);
    check("zero rbusy", 64'(d_rbusy[0]), 64'h0);
    check("zero busy_vec", 64'(d_busy_vec[0]), 64'h0);

    // Scoreboard.
    al(1, 6);
    step();
    idle();
    check("alloc r6", 64'(d_busy_vec[6]), 64'h1);
    rd(0, 6);
    step();
    idle();
    check("rbusy r6", 64'(d_rbusy[0]), 64'h1);
    wr(0, 6, 32'h77); rd(0, 6);
    step();
    idle();
    check("write clears rdata", 64'(d_rdata[31:0]), 64'h77);
    check("write clears rbusy", 64'(d_rbusy[0]), 64'h0);
    check("write clears busy_vec", 64'(d_busy_vec[6]), 64'h0);
    al(0, 6); wr(1, 6, 32'h77); rd(1, 6);
    step();
    idle();
    check("alloc+write busy", 64'(d_busy_vec[6]), 64'h1);
    check("alloc+write data", 64'(d_rdata[63:32]), 64'h77);
    check("alloc+write rbusy", 64'(d_rbusy[1]), 64'h1);

    // Sweep instance: three-way conflict, port 2 wins.
    s_wr(0, 9, 64'hA0A0_A0A0_A0A0_A0A0);
    s_wr(1, 9, 64'hB1B1_B1B1_B1B1_B1B1);
    s_wr(2, 9, 64'hC2C2_C2C2_C2C2_C2C2);
    s_rd(3, 9);
    step();
    idle();
    check("sweep 3-way conflict", s_rdata[255:192], 64'hC2C2_C2C2_C2C2_C2C2);
    s_wr(0, 10, 64'h1); s_wr(2, 10, 64'h2); s_wr(1, 11, 64'h3);
    step();
    idle();
    s_rd(1, 10); s_rd(2, 11);
    step();
    idle();
    check("sweep p2 over p0", s_rdata[127:64], 64'h2);
    check("sweep p1 alone", s_rdata[191:128], 64'h3);

    // Random traffic on both instances, with one mid-run async reset.
    for (int n = 0; n < 10000; n++) begin
      for (int p = 0; p < 2; p++) begin
        d_we[p] = ($urandom_range(0, 99) < 50);
        d_waddr[p*3 +: 3] = 3'($urandom_range(0, 7));
        d_wdata[p*32 +: 32] = $urandom;
        d_re[p] = ($urandom_range(0, 99) < 70);
        d_raddr[p*3 +: 3] = 3'($urandom_range(0, 7));
        d_alloc_en[p] = ($urandom_range(0, 99) < 30);
        d_alloc_reg[p*3 +: 3] = 3'($urandom_range(0, 7));
      end
      for (int p = 0; p < 3; p++) begin
        s_we[p] = ($urandom_range(0, 99) < 60);
        s_waddr[p*5 +: 5] = 5'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 31));
        s_wdata[p*64 +: 64] = {$urandom, $urandom};
      end
      for (int r = 0; r < 4; r++) begin
        s_re[r] = ($urandom_range(0, 99) < 70);
        s_raddr[r*5 +: 5] = 5'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 31));
      end
      s_alloc_en[0] = ($urandom_range(0, 99) < 40);
      s_alloc_reg = 5'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 31));
      if (n == 5000) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
